// File: rtl/kfpga_config_loader.sv
// kFPGA configuration loader: takes the bitstream as parallel words, shifts it
// LSB-first into the core's serial config chain, then releases the core reset.
module kfpga_config_loader #(
   parameter int CONFIG_WIDTH = 2034,
   parameter int WORD_WIDTH   = 32,
   parameter int CLEAR_CYCLES = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [WORD_WIDTH-1:0] word_data,
   input  logic                  word_valid,
   output logic                  word_ready,
   output logic                  config_in,
   output logic                  config_enable,
   output logic                  config_nreset,
   output logic                  core_nreset,
   output logic                  busy,
   output logic                  done,
   output logic                  configured
);

   localparam int NUM_WORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
   localparam int FILL_W    = $clog2(WORD_WIDTH + 1);
   localparam int TOTAL_W   = $clog2(CONFIG_WIDTH + 1);
   localparam int OWED_W    = $clog2(NUM_WORDS + 1);
   localparam int CLR_W     = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

   localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(WORD_WIDTH);
   localparam logic [FILL_W-1:0]  FILL_ONE   = FILL_W'(1);
   localparam logic [FILL_W-1:0]  FILL_ZERO  = FILL_W'(0);
   localparam logic [TOTAL_W-1:0] TOTAL_INIT = TOTAL_W'(CONFIG_WIDTH);
   localparam logic [TOTAL_W-1:0] TOTAL_ONE  = TOTAL_W'(1);
   localparam logic [TOTAL_W-1:0] TOTAL_ZERO = TOTAL_W'(0);
   localparam logic [OWED_W-1:0]  OWED_INIT  = OWED_W'(NUM_WORDS);
   localparam logic [OWED_W-1:0]  OWED_ONE   = OWED_W'(1);
   localparam logic [OWED_W-1:0]  OWED_ZERO  = OWED_W'(0);
   localparam logic [CLR_W-1:0]   CLR_LAST   = CLR_W'(CLEAR_CYCLES - 1);
   localparam logic [CLR_W-1:0]   CLR_ONE    = CLR_W'(1);
   localparam logic [CLR_W-1:0]   CLR_ZERO   = CLR_W'(0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_LOAD  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                r_state;
   logic [WORD_WIDTH-1:0] r_buffer;
   logic [FILL_W-1:0]     r_fill;
   logic [TOTAL_W-1:0]    r_total;
   logic [OWED_W-1:0]     r_owed;
   logic [CLR_W-1:0]      r_clr_cnt;
   logic                  r_config_nreset;
   logic                  r_core_nreset;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_configured;

   logic w_in_load;
   logic w_shift;
   logic w_ready;
   logic w_xfer;
   logic w_last;

   // abort masks both the shift and the handshake in the cycle it is seen
   always_comb begin
      w_in_load = (r_state == S_LOAD) && !abort;
      w_shift   = w_in_load && (r_fill != FILL_ZERO) && (r_total != TOTAL_ZERO);
      w_ready   = w_in_load && (r_fill <= FILL_ONE) && (r_owed != OWED_ZERO);
      w_xfer    = w_ready && word_valid;
      w_last    = w_shift && (r_total == TOTAL_ONE);
   end

   assign word_ready    = w_ready;
   assign config_enable = w_shift;
   assign config_in     = w_shift & r_buffer[0];
   assign config_nreset = r_config_nreset;
   assign core_nreset   = r_core_nreset;
   assign busy          = r_busy;
   assign done          = r_done;
   assign configured    = r_configured;

   // Load sequencer: state, word buffer, bit counters and registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state         <= S_IDLE;
         r_buffer        <= {WORD_WIDTH{1'b0}};
         r_fill          <= FILL_ZERO;
         r_total         <= TOTAL_ZERO;
         r_owed          <= OWED_ZERO;
         r_clr_cnt       <= CLR_ZERO;
         r_config_nreset <= 1'b0;
         r_core_nreset   <= 1'b0;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_configured    <= 1'b0;
      end else if (abort && ((r_state == S_CLEAR) || (r_state == S_LOAD))) begin
         r_state         <= S_IDLE;
         r_buffer        <= {WORD_WIDTH{1'b0}};
         r_fill          <= FILL_ZERO;
         r_total         <= TOTAL_ZERO;
         r_owed          <= OWED_ZERO;
         r_clr_cnt       <= CLR_ZERO;
         r_config_nreset <= 1'b1;
         r_core_nreset   <= 1'b0;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_configured    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state         <= S_CLEAR;
                  r_clr_cnt       <= CLR_ZERO;
                  r_configured    <= 1'b0;
                  r_config_nreset <= 1'b0;
                  r_core_nreset   <= 1'b0;
                  r_busy          <= 1'b1;
               end else begin
                  r_config_nreset <= 1'b1;
                  r_core_nreset   <= r_configured;
               end
            end
            S_CLEAR: begin
               if (r_clr_cnt == CLR_LAST) begin
                  r_state         <= S_LOAD;
                  r_config_nreset <= 1'b1;
                  r_buffer        <= {WORD_WIDTH{1'b0}};
                  r_fill          <= FILL_ZERO;
                  r_total         <= TOTAL_INIT;
                  r_owed          <= OWED_INIT;
               end else begin
                  r_clr_cnt <= r_clr_cnt + CLR_ONE;
               end
            end
            S_LOAD: begin
               // a refill on fill==1 overwrites the buffer while its last bit goes out
               if (w_xfer) begin
                  r_buffer <= word_data;
                  r_fill   <= FILL_FULL;
                  r_owed   <= r_owed - OWED_ONE;
               end else if (w_shift) begin
                  r_buffer <= {1'b0, r_buffer[WORD_WIDTH-1:1]};
                  r_fill   <= r_fill - FILL_ONE;
               end else begin
                  r_buffer <= r_buffer;
               end
               if (w_shift) begin
                  r_total <= r_total - TOTAL_ONE;
               end else begin
                  r_total <= r_total;
               end
               if (w_last) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= S_LOAD;
               end
            end
            S_DONE: begin
               r_state         <= S_IDLE;
               r_configured    <= 1'b1;
               r_core_nreset   <= 1'b1;
               r_config_nreset <= 1'b1;
               r_fill          <= FILL_ZERO;
               r_owed          <= OWED_ZERO;
            end
            default: begin
               r_state         <= S_IDLE;
               r_configured    <= 1'b0;
               r_core_nreset   <= 1'b0;
               r_config_nreset <= 1'b1;
               r_busy          <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_kfpga_config_loader.sv
// Directed bench for kfpga_config_loader: default-size instance plus a
// 64-bit/2-word instance, each observed through a model of the config chain.
module tb_kfpga_config_loader;

   localparam int CW  = 2034;
   localparam int WW  = 32;
   localparam int NW  = 64;
   localparam int CW2 = 64;
   localparam int NW2 = 2;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          reset = 1'b1;
   logic          start_a = 1'b0, abort_a = 1'b0, valid_a = 1'b0;
   logic [WW-1:0] data_a = 32'h0;
   logic          ready_a, cin_a, cen_a, cnrst_a, corenrst_a, busy_a, done_a, cfg_a;
   logic          start_b = 1'b0, abort_b = 1'b0, valid_b = 1'b0;
   logic [WW-1:0] data_b = 32'h0;
   logic          ready_b, cin_b, cen_b, cnrst_b, corenrst_b, busy_b, done_b, cfg_b;

   kfpga_config_loader dut_a (
      .clock(clock), .reset(reset), .start(start_a), .abort(abort_a),
      .word_data(data_a), .word_valid(valid_a), .word_ready(ready_a),
      .config_in(cin_a), .config_enable(cen_a), .config_nreset(cnrst_a),
      .core_nreset(corenrst_a), .busy(busy_a), .done(done_a), .configured(cfg_a)
   );

   kfpga_config_loader #(.CONFIG_WIDTH(CW2), .WORD_WIDTH(WW), .CLEAR_CYCLES(4)) dut_b (
      .clock(clock), .reset(reset), .start(start_b), .abort(abort_b),
      .word_data(data_b), .word_valid(valid_b), .word_ready(ready_b),
      .config_in(cin_b), .config_enable(cen_b), .config_nreset(cnrst_b),
      .core_nreset(corenrst_b), .busy(busy_b), .done(done_b), .configured(cfg_b)
   );

   logic [7:0] obs_a, obs_b;
   assign obs_a = {cnrst_a, corenrst_a, cfg_a, cen_a, cin_a, ready_a, busy_a, done_a};
   assign obs_b = {cnrst_b, corenrst_b, cfg_b, cen_b, cin_b, ready_b, busy_b, done_b};

   logic [WW-1:0] words [0:NW-1];
   logic [CW-1:0] exp_a;
   logic [CW2-1:0] exp_b;

   // Config-chain model and event counters for instance A
   logic [CW-1:0] sr_a = '0;
   logic stat_clr = 1'b0;
   int cyc = 0, en_a = 0, done_cnt_a = 0, acc_a = 0, clr_a = 0;
   int first_en_a = -1, last_en_a = -1;
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (!cnrst_a) sr_a <= '0;
      else if (cen_a) sr_a <= {sr_a[CW-2:0], cin_a};
      if (stat_clr) begin
         en_a <= 0; done_cnt_a <= 0; acc_a <= 0; clr_a <= 0;
         first_en_a <= -1; last_en_a <= -1;
      end else begin
         if (cen_a) begin
            en_a <= en_a + 1;
            if (first_en_a < 0) first_en_a <= cyc;
            last_en_a <= cyc;
         end
         if (done_a) done_cnt_a <= done_cnt_a + 1;
         if (valid_a && ready_a) acc_a <= acc_a + 1;
         if (!cnrst_a) clr_a <= clr_a + 1;
      end
   end

   // Same for instance B
   logic [CW2-1:0] sr_b = '0;
   int en_b = 0, rdy_b = 0, done_cnt_b = 0, acc_b = 0;
   always @(posedge clock) begin
      if (!cnrst_b) sr_b <= '0;
      else if (cen_b) sr_b <= {sr_b[CW2-2:0], cin_b};
      if (cen_b) en_b <= en_b + 1;
      if (ready_b) rdy_b <= rdy_b + 1;
      if (done_b) done_cnt_b <= done_cnt_b + 1;
      if (valid_b && ready_b) acc_b <= acc_b + 1;
   end

   int checks = 0, errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int diff_bits(input logic [CW-1:0] x, input logic [CW-1:0] y);
      int n = 0;
      for (int i = 0; i < CW; i++) if (x[i] !== y[i]) n++;
      return n;
   endfunction

   task automatic kick_a(input logic with_abort);
      @(negedge clock); stat_clr = 1'b1;
      @(negedge clock); stat_clr = 1'b0; start_a = 1'b1; abort_a = with_abort;
      @(negedge clock); start_a = 1'b0; abort_a = 1'b0;
   endtask

   // Streams words into A until done (or until abort_bits shifts have happened)
   task automatic stream_a(input int stall_words, input int abort_bits, input int start_bits,
                           output int timed_out);
      int  stall_left = 0;
      bit  stall_done = 1'b0;
      int  n = 0;
      while (done_cnt_a == 0 && n < 6000) begin
         if (abort_bits > 0 && en_a >= abort_bits) break;
         start_a = (start_bits > 0 && en_a == start_bits);
         if (stall_words > 0 && acc_a == stall_words && !stall_done && stall_left == 0 && ready_a)
            stall_left = 5;
         if (stall_left > 0) begin
            valid_a = 1'b0;
            stall_left--;
            if (stall_left == 0) stall_done = 1'b1;
         end else begin
            valid_a = (acc_a < NW);
         end
         data_a = (acc_a < NW) ? words[acc_a] : 32'hDEAD_BEEF;
         @(negedge clock);
         n++;
      end
      start_a = 1'b0;
      if (abort_bits > 0) timed_out = (en_a < abort_bits) ? 1 : 0;
      else begin
         valid_a = 1'b0;
         timed_out = (done_cnt_a == 0) ? 1 : 0;
      end
   endtask

   task automatic check_full_load(input string tag, input int exp_gaps);
      check({tag, "_en_cycles"}, en_a, CW);
      check({tag, "_gaps"}, last_en_a - first_en_a + 1 - en_a, exp_gaps);
      check({tag, "_reg_bad_bits"}, diff_bits(sr_a, exp_a), 0);
      check({tag, "_done_pulses"}, done_cnt_a, 1);
      check({tag, "_words"}, acc_a, NW);
      check({tag, "_after_done"}, {cnrst_a, corenrst_a, cfg_a, busy_a, done_a}, 5'b11100);
   endtask

   initial begin
      int to;
      for (int i = 0; i < NW; i++) words[i] = (32'(i) * 32'h9E37_79B9) ^ 32'hC3A5_5A3C;
      for (int k = 0; k < CW; k++) exp_a[CW-1-k] = words[k/WW][k%WW];
      for (int k = 0; k < CW2; k++) exp_b[CW2-1-k] = words[k/WW][k%WW];

      // Reset state, then the first IDLE cycle
      @(negedge clock);
      check("reset_a", obs_a, 8'h00);
      check("reset_b", obs_b, 8'h00);
      reset = 1'b0;
      @(negedge clock);
      check("idle_a", obs_a, 8'b1000_0000);

      // Full load, valid held high
      kick_a(1'b0);
      stream_a(0, 0, 0, to);
      check("load1_timeout", to, 0);
      check("load1_clear_cycles", clr_a, 4);
      check_full_load("load1", 0);

      // Same load with a 5-cycle valid drop while word 11 is owed
      kick_a(1'b0);
      stream_a(11, 0, 0, to);
      check("load2_timeout", to, 0);
      check_full_load("load2", 5);

      // Abort after 1000 shifted bits, with a word on offer
      kick_a(1'b0);
      stream_a(0, 1000, 0, to);
      check("abort_reach", to, 0);
      valid_a = 1'b1; abort_a = 1'b1;
      #1;
      check("abort_same_cycle", {cen_a, ready_a}, 2'b00);
      @(negedge clock);
      abort_a = 1'b0; valid_a = 1'b0;
      check("abort_next", {cnrst_a, corenrst_a, cfg_a, busy_a, done_a}, 5'b10000);
      check("abort_en_count", en_a, 1000);
      repeat (3) @(negedge clock);
      check("abort_no_done", done_cnt_a, 0);
      check("abort_idle_hold", {corenrst_a, cfg_a}, 2'b00);
      kick_a(1'b0);
      stream_a(0, 0, 0, to);
      check("load3_timeout", to, 0);
      check_full_load("load3", 0);

      // Reset mid-load
      kick_a(1'b0);
      stream_a(0, 500, 0, to);
      reset = 1'b1;
      #1;
      check("async_reset_a", obs_a, 8'h00);
      @(negedge clock);
      reset = 1'b0; valid_a = 1'b0;
      @(negedge clock);
      check("reset_idle_a", obs_a, 8'b1000_0000);
      kick_a(1'b0);
      stream_a(0, 0, 0, to);
      check("load4_timeout", to, 0);
      check("load4_clear_cycles", clr_a, 4);
      check_full_load("load4", 0);

      // abort in IDLE ignored; start+abort in IDLE starts a re-load; start in LOAD ignored
      abort_a = 1'b1;
      @(negedge clock);
      abort_a = 1'b0;
      check("idle_abort_ignored", {corenrst_a, cfg_a, busy_a}, 3'b110);
      kick_a(1'b1);
      check("reload_first_clear", {cnrst_a, corenrst_a, cfg_a, busy_a}, 4'b0001);
      stream_a(0, 0, 300, to);
      check("load5_timeout", to, 0);
      check_full_load("load5", 0);

      // Small instance: 64 bits as 2 words
      @(negedge clock); start_b = 1'b1;
      @(negedge clock); start_b = 1'b0;
      for (int n = 0; n < 300 && done_cnt_b == 0; n++) begin
         valid_b = 1'b1;
         data_b = (acc_b < NW2) ? words[acc_b] : 32'hFFFF_FFFF;
         @(negedge clock);
      end
      repeat (10) @(negedge clock);
      valid_b = 1'b0;
      check("b_ready_cycles", rdy_b, NW2);
      check("b_words", acc_b, NW2);
      check("b_en_cycles", en_b, CW2);
      check("b_done_pulses", done_cnt_b, 1);
      check("b_reg", sr_b, exp_b);
      check("b_after_done", {cnrst_b, corenrst_b, cfg_b, busy_b, done_b}, 5'b11100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
